// File: rtl/io_buttons_pkg.sv
// io_buttons_pkg: shared button-block constants used by io_buttons and data_mem
package io_buttons_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 65536;
    localparam logic [7:0] BTN_LEVEL_OFS = 8'h20;
    localparam logic [7:0] BTN_EVT_CLR_OFS = 8'h24;

    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: one pad synchronized, polarity-normalized and debounced, with a press pulse
module debounce_bit
    import io_buttons_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic level,
    output logic rise
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic differ, done;

    assign differ = sync[1] != level;
    assign done = differ && cnt == LAST;
    assign rise = done && sync[1];

    // Polarity is folded in ahead of the sync flops so that their reset value means "released".
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            cnt <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], pad ^ ACTIVE_LOW};
            cnt <= (differ && !done) ? cnt + 1'b1 : '0;
            if (done) level <= sync[1];
        end
    end

endmodule

// File: rtl/io_buttons.sv
// io_buttons: debounced button levels, sticky press events and a registered wake request
module io_buttons
    import io_buttons_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn_pad,
    input  logic             wfi,
    input  logic             clr_en,
    input  logic [WIDTH-1:0] clr_mask,
    output logic [WIDTH-1:0] btn_bus,
    output logic [WIDTH-1:0] evt_flags,
    output logic             wake
);

    logic [WIDTH-1:0] rise;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_bit (
            .clk(clk),
            .rst(rst),
            .pad(btn_pad[i]),
            .level(btn_bus[i]),
            .rise(rise[i])
        );
    end

    // Presses set flags, masked stores clear them, a simultaneous press wins; wake follows a cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_flags <= '0;
            wake <= 1'b0;
        end else begin
            evt_flags <= (evt_flags & ~(clr_en ? clr_mask : '0)) | rise;
            wake <= wfi & |evt_flags;
        end
    end

endmodule

// File: tb/tb_io_buttons.sv
// tb_io_buttons: scoreboard bench for io_buttons with DEBOUNCE_CYCLES = 4, active-low pads
module tb_io_buttons;

    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wfi = 1'b0;
    logic clr_en = 1'b0;
    logic wake;
    logic [W-1:0] btn_pad = '1;
    logic [W-1:0] clr_mask = '0;
    logic [W-1:0] btn_bus, evt_flags;

    logic [16:0] sb[$];
    logic [16:0] got, exp_v;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    io_buttons #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .btn_pad(btn_pad),
        .wfi(wfi),
        .clr_en(clr_en),
        .clr_mask(clr_mask),
        .btn_bus(btn_bus),
        .evt_flags(evt_flags),
        .wake(wake)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_pad = '1;
        wfi = 1'b0;
        clr_en = 1'b0;
        clr_mask = '0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_pad = '0;
        wfi = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            if (c == 4) begin
                rst = 1'b0;
                btn_pad = '1;
            end
            sb.push_back(17'd0);
            tick();
            got = {btn_bus, evt_flags, wake};
            exp_v = sb.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_bad++;
                $display("FAIL reset c%0d got btn=%h evt=%h wake=%b want btn=%h evt=%h wake=%b",
                         c, got[16:9], got[8:1], got[0], exp_v[16:9], exp_v[8:1], exp_v[0]);
            end
        end
        wfi = 1'b0;
    endtask

    task automatic test_press();
        logic [7:0] b, e;
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            if (c == 1) btn_pad = 8'hFE;
            if (c == 10) begin
                clr_en = 1'b1;
                clr_mask = 8'h01;
            end
            if (c == 11) begin
                clr_en = 1'b0;
                clr_mask = 8'h00;
                btn_pad = 8'hFF;
            end
            b = (c >= 6 && c < 16) ? 8'h01 : 8'h00;
            e = (c >= 6 && c < 10) ? 8'h01 : 8'h00;
            sb.push_back({b, e, 1'b0});
            tick();
            got = {btn_bus, evt_flags, wake};
            exp_v = sb.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_bad++;
                $display("FAIL press c%0d got btn=%h evt=%h wake=%b want btn=%h evt=%h wake=%b",
                         c, got[16:9], got[8:1], got[0], exp_v[16:9], exp_v[8:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] b;
        do_reset();
        for (int c = 1; c <= 18; c++) begin
            if (c == 1) btn_pad = 8'hF7;
            if (c == 4) btn_pad = 8'hFF;
            if (c == 8) btn_pad = 8'hF7;
            b = (c >= 13) ? 8'h08 : 8'h00;
            sb.push_back({b, b, 1'b0});
            tick();
            got = {btn_bus, evt_flags, wake};
            exp_v = sb.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_bad++;
                $display("FAIL glitch c%0d got btn=%h evt=%h wake=%b want btn=%h evt=%h wake=%b",
                         c, got[16:9], got[8:1], got[0], exp_v[16:9], exp_v[8:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_clear();
        logic [7:0] b, e;
        do_reset();
        for (int c = 1; c <= 11; c++) begin
            if (c == 1) btn_pad = 8'hFA;
            if (c == 7) begin
                clr_en = 1'b1;
                clr_mask = 8'h04;
            end
            if (c == 8) begin
                clr_en = 1'b0;
                clr_mask = 8'h00;
            end
            if (c == 9) clr_mask = 8'hFF;
            if (c == 10) clr_mask = 8'h00;
            b = (c >= 6) ? 8'h05 : 8'h00;
            e = (c < 6) ? 8'h00 : (c == 6) ? 8'h05 : 8'h01;
            sb.push_back({b, e, 1'b0});
            tick();
            got = {btn_bus, evt_flags, wake};
            exp_v = sb.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_bad++;
                $display("FAIL clear c%0d got btn=%h evt=%h wake=%b want btn=%h evt=%h wake=%b",
                         c, got[16:9], got[8:1], got[0], exp_v[16:9], exp_v[8:1], exp_v[0]);
            end
        end
    endtask

    task automatic test_set_wins();
        logic [7:0] b, e;
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            if (c == 1) btn_pad = 8'hFD;
            clr_en = (c == 6 || c == 8);
            clr_mask = clr_en ? 8'h02 : 8'h00;
            b = (c >= 6) ? 8'h02 : 8'h00;
            e = (c == 6 || c == 7) ? 8'h02 : 8'h00;
            sb.push_back({b, e, 1'b0});
            tick();
            got = {btn_bus, evt_flags, wake};
            exp_v = sb.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_bad++;
                $display("FAIL set_wins c%0d got btn=%h evt=%h wake=%b want btn=%h evt=%h wake=%b",
                         c, got[16:9], got[8:1], got[0], exp_v[16:9], exp_v[8:1], exp_v[0]);
            end
        end
        clr_en = 1'b0;
        clr_mask = 8'h00;
    endtask

    task automatic test_wake();
        logic [7:0] b, e;
        logic w;
        do_reset();
        for (int c = 1; c <= 13; c++) begin
            if (c == 1) begin
                wfi = 1'b1;
                btn_pad = 8'h7F;
            end
            if (c == 8) wfi = 1'b0;
            if (c == 9) wfi = 1'b1;
            clr_en = (c == 10);
            clr_mask = clr_en ? 8'hFF : 8'h00;
            b = (c >= 6) ? 8'h80 : 8'h00;
            e = (c >= 6 && c < 10) ? 8'h80 : 8'h00;
            w = (c == 7 || c == 9 || c == 10);
            sb.push_back({b, e, w});
            tick();
            got = {btn_bus, evt_flags, wake};
            exp_v = sb.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_bad++;
                $display("FAIL wake c%0d got btn=%h evt=%h wake=%b want btn=%h evt=%h wake=%b",
                         c, got[16:9], got[8:1], got[0], exp_v[16:9], exp_v[8:1], exp_v[0]);
            end
        end
        wfi = 1'b0;
        clr_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            if (c == 1) btn_pad = 8'hDF;
            if (c == 8) btn_pad = 8'hFB;
            if (c == 11) rst = 1'b1;
            if (c == 12) rst = 1'b0;
            b = (c >= 6 && c <= 10) ? 8'h20 : (c >= 17) ? 8'h04 : 8'h00;
            sb.push_back({b, b, 1'b0});
            tick();
            got = {btn_bus, evt_flags, wake};
            exp_v = sb.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_bad++;
                $display("FAIL reset_mid c%0d got btn=%h evt=%h wake=%b want btn=%h evt=%h wake=%b",
                         c, got[16:9], got[8:1], got[0], exp_v[16:9], exp_v[8:1], exp_v[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_clear();
        test_set_wins();
        test_wake();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired after %0d vectors", n_vec);
        $fatal(1);
    end

endmodule
